// File: rtl/wave_pkg.sv
// Shared encodings for the multi-mode waveform generator.
package wave_pkg;

    typedef enum logic [1:0] {
        MODE_SAW = 2'd0,
        MODE_TRI = 2'd1,
        MODE_SQR = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/prescale_tick.sv
// Step-interval counter: emits a one-cycle tick every prescaler+1 enabled cycles.
module prescale_tick #(
    parameter int PS_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                clear,
    input  logic [PS_WIDTH-1:0] prescaler,
    output logic                tick
);

    localparam logic [PS_WIDTH-1:0] PC_ZERO = {PS_WIDTH{1'b0}};
    localparam logic [PS_WIDTH-1:0] PC_ONE  = {{(PS_WIDTH-1){1'b0}}, 1'b1};

    logic [PS_WIDTH-1:0] pc_q;
    logic [PS_WIDTH-1:0] pc_d;

    // Next count and tick; a clear or a disabled cycle restarts the interval.
    always_comb begin
        tick = 1'b0;
        pc_d = pc_q;
        if (clear || !ena) begin
            pc_d = PC_ZERO;
        end else if (pc_q == prescaler) begin
            tick = 1'b1;
            pc_d = PC_ZERO;
        end else begin
            pc_d = pc_q + PC_ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_ZERO;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/multi_wave_gen.sv
// Multi-mode waveform generator: saw, triangle and square samples stepped by a
// prescaler, with a one-cycle strobe at each period end.
module multi_wave_gen
    import wave_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PS_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [1:0]          mode,
    input  logic [WIDTH-1:0]    amplitude,
    input  logic [WIDTH-1:0]    duty,
    input  logic [PS_WIDTH-1:0] prescaler,
    output logic [WIDTH-1:0]    data,
    output logic                wrap
);

    localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic [WIDTH-1:0] ph_q;
    logic [WIDTH-1:0] ph_d;
    dir_e             dir_q;
    dir_e             dir_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             mode_change_s;
    logic             tick_s;

    assign mode_change_s = (mode != mode_q);

    prescale_tick #(
        .PS_WIDTH (PS_WIDTH)
    ) u_prescale_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clear     (mode_change_s),
        .prescaler (prescaler),
        .tick      (tick_s)
    );

    // Phase/direction step, sample mux and wrap strobe.
    always_comb begin
        mode_d = mode;
        ph_d   = ph_q;
        dir_d  = dir_q;
        data_d = data_q;
        wrap_d = 1'b0;
        if (mode_change_s) begin
            ph_d   = W_ZERO;
            dir_d  = DIR_UP;
            data_d = W_ZERO;
        end else if (!ena) begin
            ph_d = ph_q;
        end else if (mode_e'(mode_q) == MODE_RSV) begin
            ph_d   = W_ZERO;
            data_d = W_ZERO;
        end else if (tick_s) begin
            case (mode_e'(mode_q))
                MODE_SAW, MODE_SQR: begin
                    // >= lets a shrunk amplitude wrap at once instead of overrunning.
                    if (ph_q >= amplitude) begin
                        ph_d   = W_ZERO;
                        wrap_d = 1'b1;
                    end else begin
                        ph_d = ph_q + W_ONE;
                    end
                    if (mode_e'(mode_q) == MODE_SQR) begin
                        data_d = (ph_d < duty) ? amplitude : W_ZERO;
                    end else begin
                        data_d = ph_d;
                    end
                end
                MODE_TRI: begin
                    if (amplitude == W_ZERO) begin
                        ph_d   = W_ZERO;
                        dir_d  = DIR_UP;
                        wrap_d = 1'b1;
                    end else if (dir_q == DIR_UP) begin
                        if (ph_q >= amplitude) begin
                            dir_d = DIR_DOWN;
                            ph_d  = amplitude - W_ONE;
                        end else begin
                            ph_d = ph_q + W_ONE;
                        end
                    end else begin
                        if (ph_q == W_ZERO) begin
                            dir_d  = DIR_UP;
                            ph_d   = W_ONE;
                            wrap_d = 1'b1;
                        end else if (ph_q > amplitude) begin
                            ph_d = amplitude;
                        end else begin
                            ph_d = ph_q - W_ONE;
                        end
                    end
                    data_d = ph_d;
                end
                default: begin
                    ph_d   = W_ZERO;
                    data_d = W_ZERO;
                end
            endcase
        end else begin
            ph_d = ph_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 2'd0;
            ph_q   <= W_ZERO;
            dir_q  <= DIR_UP;
            data_q <= W_ZERO;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            ph_q   <= ph_d;
            dir_q  <= dir_d;
            data_q <= data_d;
            wrap_q <= wrap_d;
        end
    end

    assign data = data_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// Self-checking bench for multi_wave_gen: directed scenarios plus randomized
// segments checked against a closed-form step-count model.
module tb_multi_wave_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [1:0]  mode;
    logic [15:0] amplitude;
    logic [15:0] duty;
    logic [15:0] prescaler;
    logic [15:0] data;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    // Model: steps taken since last clear, enabled edges since last restart.
    int m_mode_q, m_run, m_k, m_data, m_wrap;

    multi_wave_gen #(.WIDTH(16), .PS_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode      (mode),
        .amplitude (amplitude),
        .duty      (duty),
        .prescaler (prescaler),
        .data      (data),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode_q = 0; m_run = 0; m_k = 0; m_data = 0; m_wrap = 0;
    endtask

    // Sample value after step k, with constant parameters since the last clear.
    task automatic step_value(input int k);
        int a, p, ph;
        a = int'(amplitude);
        case (m_mode_q)
            0: begin
                m_data = k % (a + 1);
                m_wrap = (m_data == 0) ? 1 : 0;
            end
            1: begin
                if (a == 0) begin
                    m_data = 0; m_wrap = 1;
                end else begin
                    p = k % (2 * a);
                    m_data = (p <= a) ? p : (2 * a - p);
                    m_wrap = (p == 1 && k > 1) ? 1 : 0;
                end
            end
            2: begin
                ph = k % (a + 1);
                m_data = (ph < int'(duty)) ? a : 0;
                m_wrap = (ph == 0) ? 1 : 0;
            end
            default: begin
                m_data = 0; m_wrap = 0;
            end
        endcase
    endtask

    task automatic model_edge();
        if (int'(mode) != m_mode_q) begin
            m_mode_q = int'(mode);
            m_run = 0; m_k = 0; m_data = 0; m_wrap = 0;
        end else if (!ena) begin
            m_run = 0; m_wrap = 0;
        end else begin
            m_run++;
            m_wrap = 0;
            if (m_run % (int'(prescaler) + 1) == 0) begin
                m_k++;
                step_value(m_k);
            end
        end
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, ".data"}, int'(data), m_data);
        chk({tag, ".wrap"}, int'(wrap), m_wrap);
    endtask

    task automatic raw_cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset between edges, then new settings and release.
    task automatic do_reset(input logic [1:0] md, input int a, input int d,
                            input int ps, input logic en);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.data", int'(data), 0);
        chk("async_rst.wrap", int'(wrap), 0);
        model_reset();
        mode = md; amplitude = 16'(a); duty = 16'(d); prescaler = 16'(ps); ena = en;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_saw[8]  = '{0, 1, 1, 2, 2, 3, 3, 0};
        int exp_tri[8]  = '{1, 2, 3, 2, 1, 0, 1, 2};
        int frozen;

        rst_n = 1'b0; ena = 1'b0; mode = 2'd0;
        amplitude = 16'd0; duty = 16'd0; prescaler = 16'd0;
        #3;
        chk("reset.data", int'(data), 0);
        chk("reset.wrap", int'(wrap), 0);
        model_reset();
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Saw, amplitude 3, prescaler 1.
        amplitude = 16'd3; prescaler = 16'd1; ena = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc("saw");
            chk("saw_seq.data", int'(data), exp_saw[i]);
            chk("saw_seq.wrap", int'(wrap), (i == 7) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) cyc("saw2");

        // ena dropped mid-count: data frozen, first step prescaler+1 later.
        frozen = int'(data);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc("ena_low");
            chk("ena_low.frozen", int'(data), frozen);
        end
        ena = 1'b1;
        cyc("reena1");
        chk("reena.no_step", int'(data), frozen);
        cyc("reena2");
        chk("reena.step", int'(data), (frozen + 1) % 4);

        // Mode switch saw -> triangle clears to 0 without wrap.
        mode = 2'd1; prescaler = 16'd0;
        cyc("to_tri");
        chk("to_tri.data", int'(data), 0);
        chk("to_tri.wrap", int'(wrap), 0);
        for (int i = 0; i < 8; i++) begin
            cyc("tri");
            chk("tri_seq.data", int'(data), exp_tri[i]);
            chk("tri_seq.wrap", int'(wrap), (i == 6) ? 1 : 0);
        end

        // Triangle, amplitude 0: constant 0, wrap every cycle.
        do_reset(2'd1, 0, 0, 0, 1'b1);
        cyc("tri0_clear");
        for (int i = 0; i < 6; i++) begin
            cyc("tri0");
            chk("tri0.wrap_every", int'(wrap), 1);
        end

        // Square, amplitude 100, duty 2 / 0 / 200.
        do_reset(2'd2, 100, 2, 0, 1'b1);
        for (int i = 0; i < 110; i++) cyc("sqr_d2");
        do_reset(2'd2, 100, 0, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc("sqr_d0");
            chk("sqr_d0.const", int'(data), 0);
        end
        do_reset(2'd2, 100, 200, 0, 1'b1);
        cyc("sqr_d200_clear");
        for (int i = 0; i < 20; i++) begin
            cyc("sqr_d200");
            chk("sqr_d200.const", int'(data), 100);
        end

        // Saw at ph 10, amplitude lowered to 5: immediate wrap, no overrun.
        do_reset(2'd0, 20, 0, 0, 1'b1);
        for (int i = 0; i < 10; i++) cyc("shrink_pre");
        chk("shrink.at10", int'(data), 10);
        amplitude = 16'd5;
        raw_cyc();
        chk("shrink.data", int'(data), 0);
        chk("shrink.wrap", int'(wrap), 1);
        raw_cyc();
        chk("shrink.next", int'(data), 1);
        chk("shrink.next_wrap", int'(wrap), 0);

        // ena low and mode change in one cycle: the clear wins.
        do_reset(2'd0, 7, 0, 2, 1'b1);
        for (int i = 0; i < 10; i++) cyc("pre_mc");
        ena = 1'b0; mode = 2'd2; duty = 16'd3;
        cyc("mc_ena_low");
        chk("mc_ena_low.data", int'(data), 0);
        ena = 1'b1;
        for (int i = 0; i < 30; i++) cyc("post_mc");

        // Reset mid-period, then restart from phase 0.
        do_reset(2'd0, 7, 0, 2, 1'b1);
        for (int i = 0; i < 12; i++) cyc("restart");

        // Randomized segments, each opened by a mode change.
        for (int s = 0; s < 30; s++) begin
            int len;
            mode      = 2'((m_mode_q + 1 + int'($urandom % 3)) % 4);
            amplitude = 16'($urandom % 10);
            duty      = 16'($urandom % 12);
            prescaler = 16'($urandom % 4);
            ena       = 1'($urandom % 2);
            len       = 20 + int'($urandom % 40);
            for (int i = 0; i < len; i++) begin
                cyc("rand");
                ena = ($urandom % 8 != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
